// File: rtl/sdram_responder.sv
// SDRAM device-side responder: decodes controller commands, tracks per-bank row state,
// stores write data and returns reads at the programmed CAS latency, flagging protocol violations.
module sdram_responder #(
    parameter int T_RCD      = 3,
    parameter int CL_DEFAULT = 3,
    parameter int ROW_BITS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_cle,
    input  logic        sdram_cs,
    input  logic        sdram_ras,
    input  logic        sdram_cas,
    input  logic        sdram_we,
    input  logic        sdram_dqm,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_a,
    input  logic [31:0] sdram_dqi,
    output logic [31:0] sdram_dqo,
    output logic        rd_valid,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int AGE_W = ($clog2(T_RCD + 1) > 3) ? $clog2(T_RCD + 1) : 3;
    localparam int IDX_W = 10 + ROW_BITS;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(T_RCD);
    // age_r reads (edges since ACTIVE) - 1 when a command is sampled
    localparam logic [AGE_W-1:0] AGE_MIN = AGE_W'(T_RCD - 1);

    typedef enum logic [3:0] {
        CMD_UNSEL = 4'd0,
        CMD_NOP   = 4'd1,
        CMD_ACT   = 4'd2,
        CMD_READ  = 4'd3,
        CMD_WRITE = 4'd4,
        CMD_TERM  = 4'd5,
        CMD_PRE   = 4'd6,
        CMD_REF   = 4'd7,
        CMD_LMR   = 4'd8
    } cmd_t;

    cmd_t               cmd_s;
    logic               open_r [4];
    logic [12:0]        row_r  [4];
    logic [AGE_W-1:0]   age_r  [4];
    logic [1:0]         cl_r;
    logic               err_r;
    logic [2:0]         err_code_r;
    logic               pipe_v_r [3];
    logic [31:0]        pipe_d_r [3];
    logic               rd_valid_r;
    logic [31:0]        dqo_r;
    logic [31:0]        mem_r [DEPTH];

    logic               bank_open_s;
    logic               age_ok_s;
    logic               any_open_s;
    logic               mode_cl_ok_s;
    logic [ROW_BITS-1:0] row_sel_s;
    logic [IDX_W-1:0]   idx_s;
    logic [31:0]        rd_data_s;
    logic               viol_s;
    logic [2:0]         viol_code_s;
    logic               act_s;
    logic               pre_one_s;
    logic               pre_all_s;
    logic               rd_issue_s;
    logic               wr_en_s;
    logic               cl_load_s;
    logic               unused_row_s;

    // Command decode; a deselected clock-enable turns any command into NOP
    always_comb begin
        cmd_s = CMD_NOP;
        if (sdram_cs) begin
            cmd_s = CMD_UNSEL;
        end else if (!sdram_cle) begin
            cmd_s = CMD_NOP;
        end else begin
            case ({sdram_ras, sdram_cas, sdram_we})
                3'b111:  cmd_s = CMD_NOP;
                3'b011:  cmd_s = CMD_ACT;
                3'b101:  cmd_s = CMD_READ;
                3'b100:  cmd_s = CMD_WRITE;
                3'b110:  cmd_s = CMD_TERM;
                3'b010:  cmd_s = CMD_PRE;
                3'b001:  cmd_s = CMD_REF;
                3'b000:  cmd_s = CMD_LMR;
                default: cmd_s = CMD_NOP;
            endcase
        end
    end

    // Addressed-bank status, storage index and the pre-edge storage word
    always_comb begin
        bank_open_s  = open_r[sdram_ba];
        age_ok_s     = (age_r[sdram_ba] >= AGE_MIN);
        any_open_s   = open_r[0] | open_r[1] | open_r[2] | open_r[3];
        mode_cl_ok_s = (sdram_a[6:4] == 3'd2) || (sdram_a[6:4] == 3'd3);
        row_sel_s    = row_r[sdram_ba][ROW_BITS-1:0];
        idx_s        = {sdram_ba, row_sel_s, sdram_a[9:2]};
        rd_data_s    = mem_r[idx_s];
        unused_row_s = ^row_r[0] ^ ^row_r[1] ^ ^row_r[2] ^ ^row_r[3];
    end

    // Command effects and protocol-violation classification
    always_comb begin
        viol_s      = 1'b0;
        viol_code_s = 3'd0;
        act_s       = 1'b0;
        pre_one_s   = 1'b0;
        pre_all_s   = 1'b0;
        rd_issue_s  = 1'b0;
        wr_en_s     = 1'b0;
        cl_load_s   = 1'b0;
        case (cmd_s)
            CMD_ACT: begin
                if (bank_open_s) begin
                    viol_s      = 1'b1;
                    viol_code_s = 3'd1;
                end else begin
                    act_s = 1'b1;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!bank_open_s) begin
                    viol_s      = 1'b1;
                    viol_code_s = 3'd2;
                end else begin
                    // a too-early access is flagged but still performed
                    if (!age_ok_s) begin
                        viol_s      = 1'b1;
                        viol_code_s = 3'd3;
                    end else begin
                        viol_s = 1'b0;
                    end
                    rd_issue_s = (cmd_s == CMD_READ);
                    wr_en_s    = (cmd_s == CMD_WRITE) && !sdram_dqm;
                end
            end
            CMD_PRE: begin
                if (sdram_a[10]) begin
                    pre_all_s = 1'b1;
                end else begin
                    pre_one_s = 1'b1;
                end
            end
            CMD_REF: begin
                if (any_open_s) begin
                    viol_s      = 1'b1;
                    viol_code_s = 3'd4;
                end else begin
                    viol_s = 1'b0;
                end
            end
            CMD_LMR: begin
                if (mode_cl_ok_s) begin
                    cl_load_s = 1'b1;
                end else begin
                    viol_s      = 1'b1;
                    viol_code_s = 3'd5;
                end
            end
            default: begin
                viol_s = 1'b0;
            end
        endcase
    end

    // Per-bank open flag, open row and saturating activation age
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                open_r[b] <= 1'b0;
                row_r[b]  <= 13'd0;
                age_r[b]  <= AGE_SAT;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (act_s && (sdram_ba == 2'(b))) begin
                    open_r[b] <= 1'b1;
                    row_r[b]  <= sdram_a;
                    age_r[b]  <= {AGE_W{1'b0}};
                end else begin
                    if (pre_all_s || (pre_one_s && (sdram_ba == 2'(b)))) begin
                        open_r[b] <= 1'b0;
                    end
                    if (age_r[b] < AGE_SAT) begin
                        age_r[b] <= age_r[b] + AGE_W'(1);
                    end
                end
            end
        end
    end

    // CAS latency register; only values 2 and 3 are ever loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            cl_r <= 2'(CL_DEFAULT);
        end else if (cl_load_s) begin
            cl_r <= sdram_a[5:4];
        end
    end

    // Sticky first-violation capture
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r      <= 1'b0;
            err_code_r <= 3'd0;
        end else if (viol_s && !err_r) begin
            err_r      <= 1'b1;
            err_code_r <= viol_code_s;
        end
    end

    // Storage array; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= sdram_dqi;
        end
    end

    // Read pipeline: a READ enters at stage CL-1 so it reaches the output register CL edges later
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                pipe_v_r[i] <= 1'b0;
                pipe_d_r[i] <= 32'd0;
            end
            rd_valid_r <= 1'b0;
            dqo_r      <= 32'd0;
        end else begin
            pipe_v_r[0] <= pipe_v_r[1];
            pipe_d_r[0] <= pipe_d_r[1];
            pipe_v_r[1] <= pipe_v_r[2];
            pipe_d_r[1] <= pipe_d_r[2];
            pipe_v_r[2] <= 1'b0;
            pipe_d_r[2] <= 32'd0;
            if (rd_issue_s) begin
                if (cl_r == 2'd2) begin
                    pipe_v_r[1] <= 1'b1;
                    pipe_d_r[1] <= rd_data_s;
                end else begin
                    pipe_v_r[2] <= 1'b1;
                    pipe_d_r[2] <= rd_data_s;
                end
            end
            rd_valid_r <= pipe_v_r[0];
            dqo_r      <= pipe_v_r[0] ? pipe_d_r[0] : 32'd0;
        end
    end

    assign sdram_dqo = dqo_r;
    assign rd_valid  = rd_valid_r;
    assign err       = err_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: timestamp/associative-array model of the device checked every
// cycle, directed scenarios with literal expectations, then randomized command traffic.
module tb_sdram_responder;

    localparam int T_RCD      = 3;
    localparam int CL_DEFAULT = 3;
    localparam int ROW_BITS   = 2;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_TERM = 4'b0110;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;

    logic        clk = 1'b0;
    logic        rst, cle, cs, ras, cas, we, dqm;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [31:0] dqi, dqo;
    logic        rd_valid, err;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_responder #(.T_RCD(T_RCD), .CL_DEFAULT(CL_DEFAULT), .ROW_BITS(ROW_BITS)) dut (
        .clk(clk), .rst(rst),
        .sdram_cle(cle), .sdram_cs(cs), .sdram_ras(ras), .sdram_cas(cas), .sdram_we(we),
        .sdram_dqm(dqm), .sdram_ba(ba), .sdram_a(a), .sdram_dqi(dqi),
        .sdram_dqo(dqo), .rd_valid(rd_valid), .err(err), .err_code(err_code)
    );

    // Reference model: banks remember the edge number of their ACTIVE; reads are
    // scheduled into a map keyed by the edge number after which they must appear.
    bit          m_open [4];
    int          m_row  [4];
    int          m_act  [4];
    int          m_cl;
    bit          m_err;
    int          m_code;
    int          edge_n = 0;
    logic [31:0] m_mem   [int];
    logic [31:0] exp_dat [int];
    bit          exp_kn  [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (edge %0d)", name, act, expv, edge_n);
        end
    endtask

    function automatic void viol(input int code);
        if (!m_err) begin
            m_err  = 1'b1;
            m_code = code;
        end
    endfunction

    task automatic model_edge();
        int b;
        int idx;
        edge_n++;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
            m_cl   = CL_DEFAULT;
            m_err  = 1'b0;
            m_code = 0;
            exp_dat.delete();
            exp_kn.delete();
            return;
        end
        if (cs || !cle) return;
        b   = int'(ba);
        idx = (b << (8 + ROW_BITS)) + ((m_row[b] % (1 << ROW_BITS)) << 8) + int'(a[9:2]);
        case ({ras, cas, we})
            3'b011: begin
                if (m_open[b]) viol(1);
                else begin
                    m_open[b] = 1'b1;
                    m_row[b]  = int'(a);
                    m_act[b]  = edge_n;
                end
            end
            3'b101, 3'b100: begin
                if (!m_open[b]) viol(2);
                else begin
                    if (edge_n - m_act[b] < T_RCD) viol(3);
                    if (we) begin
                        exp_kn[edge_n + m_cl]  = m_mem.exists(idx);
                        exp_dat[edge_n + m_cl] = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
                    end else if (!dqm) begin
                        m_mem[idx] = dqi;
                    end
                end
            end
            3'b010: begin
                if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
                else m_open[b] = 1'b0;
            end
            3'b001: begin
                if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) viol(4);
            end
            3'b000: begin
                if (a[6:4] == 3'd2 || a[6:4] == 3'd3) m_cl = int'(a[6:4]);
                else viol(5);
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        bit ev;
        ev = exp_dat.exists(edge_n);
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, ev});
        if (!ev) chk("dqo_idle", dqo, 32'd0);
        else if (exp_kn[edge_n]) chk("dqo_data", dqo, exp_dat[edge_n]);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("err_code", {29'd0, err_code}, m_code);
        if (ev) begin
            exp_dat.delete(edge_n);
            exp_kn.delete(edge_n);
        end
    endtask

    // Model consumes the inputs at each rising edge, then outputs are compared just after it
    always @(posedge clk) begin
        model_edge();
        #1;
        compare();
    end

    task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [31:0] d, input logic m);
        {cs, ras, cas, we} = c;
        ba  = b;
        a   = addr;
        dqi = d;
        dqm = m;
        cle = 1'b1;
        @(negedge clk);
        {cs, ras, cas, we} = C_NOP;
    endtask

    task automatic nop(input int n);
        repeat (n) cmd(C_NOP, 2'd0, 13'd0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cle = 1'b1; {cs, ras, cas, we} = C_NOP;
        ba = 2'd0; a = 13'd0; dqi = 32'd0; dqm = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_code", {29'd0, err_code}, 32'd0);
        chk("reset_dqo", dqo, 32'd0);

        // write/read round trip at default latency
        cmd(C_ACT, 2'd1, 13'd5, 32'd0, 1'b0);
        nop(4);
        cmd(C_WR, 2'd1, 13'h048, 32'hDEADBEEF, 1'b0);
        cmd(C_RD, 2'd1, 13'h048, 32'd0, 1'b0);
        nop(2);
        chk("cl3_not_early", {31'd0, rd_valid}, 32'd0);
        nop(1);
        chk("cl3_valid", {31'd0, rd_valid}, 32'd1);
        chk("cl3_data", dqo, 32'hDEADBEEF);
        chk("cl3_no_err", {31'd0, err}, 32'd0);

        // CL=2 then illegal mode value keeps CL=2
        do_reset();
        cmd(C_LMR, 2'd0, 13'h020, 32'd0, 1'b0);
        cmd(C_ACT, 2'd0, 13'd7, 32'd0, 1'b0);
        nop(3);
        cmd(C_WR, 2'd0, 13'h010, 32'h12345678, 1'b0);
        cmd(C_RD, 2'd0, 13'h010, 32'd0, 1'b0);
        nop(1);
        chk("cl2_not_early", {31'd0, rd_valid}, 32'd0);
        nop(1);
        chk("cl2_valid", {31'd0, rd_valid}, 32'd1);
        chk("cl2_data", dqo, 32'h12345678);
        cmd(C_LMR, 2'd0, 13'h050, 32'd0, 1'b0);
        chk("bad_mode_err", {31'd0, err}, 32'd1);
        chk("bad_mode_code", {29'd0, err_code}, 32'd5);
        cmd(C_RD, 2'd0, 13'h010, 32'd0, 1'b0);
        nop(2);
        chk("cl2_kept_valid", {31'd0, rd_valid}, 32'd1);

        // access to closed bank, then a second violation must not overwrite the code
        do_reset();
        cmd(C_RD, 2'd0, 13'd0, 32'd0, 1'b0);
        chk("closed_code", {29'd0, err_code}, 32'd2);
        nop(4);
        cmd(C_ACT, 2'd2, 13'd0, 32'd0, 1'b0);
        cmd(C_ACT, 2'd2, 13'd0, 32'd0, 1'b0);
        chk("first_code_kept", {29'd0, err_code}, 32'd2);

        // tRCD violation still returns data
        do_reset();
        cmd(C_ACT, 2'd3, 13'd1, 32'd0, 1'b0);
        nop(3);
        cmd(C_WR, 2'd3, 13'h010, 32'hCAFEF00D, 1'b0);
        cmd(C_PRE, 2'd3, 13'd0, 32'd0, 1'b0);
        cmd(C_ACT, 2'd3, 13'd1, 32'd0, 1'b0);
        nop(1);
        cmd(C_RD, 2'd3, 13'h010, 32'd0, 1'b0);
        chk("trcd_code", {29'd0, err_code}, 32'd3);
        nop(3);
        chk("trcd_data", dqo, 32'hCAFEF00D);

        // masked write, precharge-all then refresh
        do_reset();
        cmd(C_ACT, 2'd0, 13'd2, 32'd0, 1'b0);
        nop(3);
        cmd(C_WR, 2'd0, 13'h024, 32'hAAAAAAAA, 1'b0);
        cmd(C_WR, 2'd0, 13'h024, 32'h11111111, 1'b1);
        cmd(C_RD, 2'd0, 13'h024, 32'd0, 1'b0);
        nop(3);
        chk("masked_data", dqo, 32'hAAAAAAAA);
        cmd(C_PRE, 2'd0, 13'h400, 32'd0, 1'b0);
        cmd(C_REF, 2'd0, 13'd0, 32'd0, 1'b0);
        chk("refresh_ok", {31'd0, err}, 32'd0);

        // reset during a pending read
        do_reset();
        cmd(C_ACT, 2'd1, 13'd3, 32'd0, 1'b0);
        nop(3);
        cmd(C_RD, 2'd1, 13'd0, 32'd0, 1'b0);
        do_reset();
        nop(5);
        chk("rst_cancel_err", {31'd0, err}, 32'd0);
        cmd(C_RD, 2'd1, 13'd0, 32'd0, 1'b0);
        chk("rst_closed_code", {29'd0, err_code}, 32'd2);

        // randomized traffic; periodic resets clear the sticky flag
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [12:0] ad;
            r  = $urandom_range(0, 99);
            ad = 13'($urandom);
            ad[9:2] = 8'($urandom_range(0, 7));
            rst = (i % 250 == 0) || ($urandom_range(0, 299) == 0);
            cle = ($urandom_range(0, 19) != 0);
            ba  = 2'($urandom_range(0, 3));
            dqi = $urandom;
            dqm = ($urandom_range(0, 7) == 0);
            if (r < 15)      {cs, ras, cas, we} = C_NOP;
            else if (r < 22) {cs, ras, cas, we} = {1'b1, 3'($urandom)};
            else if (r < 25) {cs, ras, cas, we} = C_TERM;
            else if (r < 42) {cs, ras, cas, we} = C_ACT;
            else if (r < 62) {cs, ras, cas, we} = C_RD;
            else if (r < 80) {cs, ras, cas, we} = C_WR;
            else if (r < 92) begin
                {cs, ras, cas, we} = C_PRE;
                ad[10] = ($urandom_range(0, 3) == 0);
            end else if (r < 95) {cs, ras, cas, we} = C_REF;
            else begin
                {cs, ras, cas, we} = C_LMR;
                if ($urandom_range(0, 4) != 0) ad[6:4] = 3'($urandom_range(2, 3));
            end
            a = ad;
            @(negedge clk);
        end
        rst = 1'b0;
        nop(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter T_RCD, default 3; meaning: minimum number of clock edges from ACTIVE to READ/WRITE on the same bank.
REQ-002 SHALL have parameter CL_DEFAULT, default 3; meaning: read CAS latency after reset (legal values 2, 3).
REQ-003 SHALL have parameter ROW_BITS, default 2; meaning: low row-address bits kept in the storage index.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sdram_cle, sdram_cs, sdram_ras, sdram_cas, sdram_we, sdram_dqm  input  1 each  command/control pins.
REQ-007 sdram_ba  input  2  bank address; sdram_a  input  13  row/column/mode address.
REQ-008 sdram_dqi  input  32  write data from controller.
REQ-009 sdram_dqo  output  32  read data to controller.
REQ-010 rd_valid  output  1  high for exactly the cycle in which sdram_dqo carries read data.
REQ-011 err  output  1  sticky protocol-violation flag; err_code  output  3  code of the first violation.

Function
REQ-012 Decode {cs,ras,cas,we} at each edge: 1xxx UNSELECTED, 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0110 TERMINATE, 0010 PRECHARGE, 0001 REFRESH, 0000 LOAD_MODE.
REQ-013 cle=0 SHALL cause the sampled command to be treated as NOP; the read pipeline still advances.
REQ-014 UNSELECTED, NOP and TERMINATE SHALL cause no state change.
REQ-015 Per-bank state: open flag, open row (13 b), and a saturating activation-age counter (≥3 b, saturates at T_RCD).
REQ-016 ACTIVE to a closed bank: set open, latch row = a, clear age; ACTIVE to an open bank: error code 1, bank state unchanged.
REQ-017 PRECHARGE: a[10]=1 closes all banks; a[10]=0 closes bank ba; precharging a closed bank is legal.
REQ-018 READ/WRITE to a closed bank: error code 2, no access, no rd_valid.
REQ-019 READ/WRITE when bank age < T_RCD: error code 3; the access still executes.
REQ-020 REFRESH with any bank open: error code 4; otherwise no effect.
REQ-021 LOAD_MODE: if a[6:4] is 2 or 3, CL = a[6:4]; otherwise error code 5, CL unchanged.
REQ-022 Column = a[9:2]; storage index = {ba, open_row[ROW_BITS-1:0], a[9:2]}; storage is 2^(10+ROW_BITS) x 32, contents undefined after power-up and not cleared by reset.
REQ-023 WRITE: sdram_dqi sampled on the same edge as the command; written to storage unless dqm=1 (masked, no write).
REQ-024 READ sampled at edge k: data = storage content as of edge k (not updated by later writes); sdram_dqo = data and rd_valid=1 after edge k+CL, for one cycle.
REQ-025 Read pipeline depth 3, one entry per edge; back-to-back READs every cycle SHALL each return in order at their own latency.
REQ-026 A CL change via LOAD_MODE SHALL apply only to READs sampled after it.
REQ-027 When rd_valid=0, sdram_dqo SHALL be 0.
REQ-028 err sets on the first violation and holds until rst; err_code captures that first code only; later violations do not overwrite it.
REQ-029 Burst length is 1; mode-register burst fields are ignored.

Reset
REQ-030 rst=1 at an edge: all banks closed, ages saturated, CL=CL_DEFAULT, read pipeline flushed, rd_valid=0, sdram_dqo=0, err=0, err_code=0.
REQ-031 rst asserted mid-read SHALL cancel all pending reads; no rd_valid after reset.

Verification
REQ-032 ACTIVE ba=1 row=5; 4 NOPs; WRITE col 0x12 dqi=0xDEADBEEF; READ same -> rd_valid 3 edges after READ, dqo=0xDEADBEEF, err=0.
REQ-033 LOAD_MODE a[6:4]=2, then ACTIVE/READ -> data at edge k+2; LOAD_MODE a[6:4]=5 -> err=1, err_code=5, CL stays 2.
REQ-034 READ bank 0 after reset (no ACTIVE) -> err_code=2, no rd_valid; ACTIVE bank 2 twice -> err_code stays 2.
REQ-035 ACTIVE then READ on the 2nd edge (T_RCD=3) -> err_code=3, data still returned at CL.
REQ-036 WRITE 0x11111111 with dqm=1 over prior 0xAAAAAAAA -> read returns 0xAAAAAAAA; PRECHARGE a[10]=1 then REFRESH -> no error.
REQ-037 READ issued, rst on the next edge -> rd_valid never asserts, err=0, all banks closed.
